// File: rtl/vga_text_console_if.sv
// Byte-stream input and VGA character-memory port of the text console.
// master = environment (byte source + memory), slave = console.
interface vga_text_console_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        char_we;
  logic [11:0] char_addr;
  logic [31:0] char_value;
  logic [31:0] char_read;

  modport master (
    output in_valid, in_data, char_read,
    input  in_ready, char_we, char_addr, char_value
  );

  modport slave (
    input  in_valid, in_data, char_read,
    output in_ready, char_we, char_addr, char_value
  );
endinterface

// File: rtl/vga_text_console.sv
// Text console: cursor, CR/LF/BS/FF, clear and scroll over the VGA char port. `define CONSOLE_AUTOSCROLL_EN to scroll at the bottom row.
// Glyph written 1 cycle after accept; in_ready low (byte stalls) until back in IDLE, busy during CLR/SCR_*.
module vga_text_console #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         RD_LAT     = 1,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_text_console_if.slave bus,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);
  localparam logic [6:0]  C_LAST  = 7'(COLS - 1);
  localparam logic [4:0]  R_LAST  = 5'(ROWS - 1);
  localparam logic [31:0] BLANK_W = {24'd0, 1'b0, BLANK_CHAR[6:0]};

`ifdef CONSOLE_AUTOSCROLL_EN
  localparam logic [1:0] L_LAST = 2'(RD_LAT - 1);
  typedef enum logic [2:0] {IDLE, PUT, CLR, SCR_RD, SCR_WR, SCR_FILL} state_t;
`else
  typedef enum logic [2:0] {IDLE, PUT, CLR} state_t;
`endif

  state_t     r_state, w_state_n;
  logic       r_rdy;
  logic [6:0] r_col, w_col_n, r_scol, w_scol_n;
  logic [4:0] r_row, w_row_n, r_srow, w_srow_n, r_end, w_end_n;
  logic [6:0] r_ch, w_ch_n;
  logic       r_adv, w_adv_n;
  logic       w_acc, w_nl;
`ifdef CONSOLE_AUTOSCROLL_EN
  logic [1:0]  r_lat, w_lat_n;
  logic [31:0] r_word, w_word_n;
`endif

  assign w_acc        = bus.in_valid & bus.in_ready;
  assign bus.in_ready = r_rdy && (r_state == IDLE);
  assign busy         = (r_state != IDLE) && (r_state != PUT);
  assign cursor_col   = r_col;
  assign cursor_row   = r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_scol  <= '0;
      r_srow  <= '0;
      r_end   <= '0;
      r_ch    <= '0;
      r_adv   <= 1'b0;
`ifdef CONSOLE_AUTOSCROLL_EN
      r_lat   <= '0;
      r_word  <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_rdy   <= 1'b1;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      r_scol  <= w_scol_n;
      r_srow  <= w_srow_n;
      r_end   <= w_end_n;
      r_ch    <= w_ch_n;
      r_adv   <= w_adv_n;
`ifdef CONSOLE_AUTOSCROLL_EN
      r_lat   <= w_lat_n;
      r_word  <= w_word_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_row_n   = r_row;
    w_scol_n  = r_scol;
    w_srow_n  = r_srow;
    w_end_n   = r_end;
    w_ch_n    = r_ch;
    w_adv_n   = r_adv;
    w_nl      = 1'b0;
`ifdef CONSOLE_AUTOSCROLL_EN
    w_lat_n   = r_lat;
    w_word_n  = r_word;
`endif
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          case (bus.in_data)
            8'h0D: w_col_n = '0;
            8'h0A: w_nl = 1'b1;
            8'h08: begin
              // Backspace never wraps to the previous row.
              if (r_col != '0) begin
                w_col_n   = r_col - 7'd1;
                w_ch_n    = BLANK_CHAR[6:0];
                w_adv_n   = 1'b0;
                w_state_n = PUT;
              end
            end
            8'h0C: begin
              w_srow_n  = '0;
              w_scol_n  = '0;
              w_end_n   = R_LAST;
              w_state_n = CLR;
            end
            default: begin
              if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                w_ch_n    = bus.in_data[6:0];
                w_adv_n   = 1'b1;
                w_state_n = PUT;
              end
            end
          endcase
        end
      end
      PUT: begin
        w_state_n = IDLE;
        if (r_adv) begin
          if (r_col == C_LAST) w_nl = 1'b1;
          else                 w_col_n = r_col + 7'd1;
        end
      end
      CLR: begin
        // Sweeps rows r_srow..r_end; serves both form-feed and the row-0 wrap blank.
        if (r_scol == C_LAST) begin
          w_scol_n = '0;
          if (r_srow == r_end) begin
            w_state_n = IDLE;
            w_row_n   = '0;
            w_col_n   = '0;
          end else begin
            w_srow_n = r_srow + 5'd1;
          end
        end else begin
          w_scol_n = r_scol + 7'd1;
        end
      end
`ifdef CONSOLE_AUTOSCROLL_EN
      SCR_RD: begin
        if (r_lat == L_LAST) begin
          w_word_n  = bus.char_read;
          w_state_n = SCR_WR;
        end else begin
          w_lat_n = r_lat + 2'd1;
        end
      end
      SCR_WR: begin
        w_lat_n   = '0;
        w_state_n = SCR_RD;
        if (r_scol == C_LAST) begin
          w_scol_n = '0;
          if (r_srow == R_LAST) w_state_n = SCR_FILL;
          else                  w_srow_n  = r_srow + 5'd1;
        end else begin
          w_scol_n = r_scol + 7'd1;
        end
      end
      SCR_FILL: begin
        if (r_scol == C_LAST) begin
          w_state_n = IDLE;
          w_row_n   = R_LAST;
          w_col_n   = '0;
        end else begin
          w_scol_n = r_scol + 7'd1;
        end
      end
`endif
      default: w_state_n = IDLE;
    endcase

    if (w_nl) begin
      w_col_n = '0;
      if (r_row != R_LAST) begin
        w_row_n = r_row + 5'd1;
      end else begin
        w_scol_n = '0;
`ifdef CONSOLE_AUTOSCROLL_EN
        w_lat_n = '0;
        if (ROWS > 1) begin
          w_srow_n  = 5'd1;
          w_state_n = SCR_RD;
        end else begin
          w_state_n = SCR_FILL;
        end
`else
        w_row_n   = '0;
        w_srow_n  = '0;
        w_end_n   = '0;
        w_state_n = CLR;
`endif
      end
    end
  end

  always_comb begin
    bus.char_we    = 1'b0;
    bus.char_addr  = {r_row, r_col};
    bus.char_value = 32'd0;
    case (r_state)
      PUT: begin
        bus.char_we    = 1'b1;
        bus.char_value = {25'd0, r_ch};
      end
      CLR: begin
        bus.char_we    = 1'b1;
        bus.char_addr  = {r_srow, r_scol};
        bus.char_value = BLANK_W;
      end
`ifdef CONSOLE_AUTOSCROLL_EN
      SCR_RD: bus.char_addr = {r_srow, r_scol};
      SCR_WR: begin
        bus.char_we    = 1'b1;
        bus.char_addr  = {r_srow - 5'd1, r_scol};
        bus.char_value = r_word;
      end
      SCR_FILL: begin
        bus.char_we    = 1'b1;
        bus.char_addr  = {R_LAST, r_scol};
        bus.char_value = BLANK_W;
      end
`endif
      default: ;
    endcase
  end
endmodule
